// File: rtl/wb_scoreboard_pkg.sv
// wb_scoreboard_pkg: shared forward codes, read-select codes and register index width
package wb_scoreboard_pkg;
  localparam int REG_W = 5;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_WB    = 2'b11;
  localparam logic [1:0] RA_RSRT   = 2'b00;
  localparam logic [1:0] RA_RS     = 2'b01;
  localparam logic [1:0] RA_RT     = 2'b11;
  localparam logic [1:0] RA_NONE   = 2'b10;
endpackage

// File: rtl/wb_scoreboard_match.sv
// sb_match: hit when a used source reads the live destination of one in-flight entry
module sb_match #(
  parameter int REG_W = 5
) (
  input  logic             v,
  input  logic [REG_W-1:0] wd,
  input  logic [REG_W-1:0] src,
  input  logic             en,
  output logic             hit
);
  assign hit = en & v & (|wd) & (wd == src);
endmodule

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: load-use stall and registered EX forward selects for the 5-stage pipeline.
// Defining WB_SCOREBOARD_WB_BYPASS_EN adds the WB entry as a lowest-priority bypass source.
module wb_scoreboard #(
  parameter int REG_W = wb_scoreboard_pkg::REG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [1:0]       id_ra_sel,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wd,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [15:0]      stall_cnt
);
  import wb_scoreboard_pkg::*;
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] wd;
    logic             ld;
  } entry_t;
  entry_t ex, mem, wb;
  logic use_rs, use_rt, ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt, kill, unused_wb;
  logic [1:0] fa_d, fb_d;
  assign use_rs = id_valid & (id_ra_sel == RA_RSRT | id_ra_sel == RA_RS);
  assign use_rt = id_valid & (id_ra_sel == RA_RSRT | id_ra_sel == RA_RT);
  sb_match #(.REG_W(REG_W)) m_ex_rs  (.v(ex.v),  .wd(ex.wd),  .src(id_rs), .en(use_rs), .hit(ex_rs));
  sb_match #(.REG_W(REG_W)) m_ex_rt  (.v(ex.v),  .wd(ex.wd),  .src(id_rt), .en(use_rt), .hit(ex_rt));
  sb_match #(.REG_W(REG_W)) m_mem_rs (.v(mem.v), .wd(mem.wd), .src(id_rs), .en(use_rs), .hit(mem_rs));
  sb_match #(.REG_W(REG_W)) m_mem_rt (.v(mem.v), .wd(mem.wd), .src(id_rt), .en(use_rt), .hit(mem_rt));
`ifdef WB_SCOREBOARD_WB_BYPASS_EN
  sb_match #(.REG_W(REG_W)) m_wb_rs  (.v(wb.v),  .wd(wb.wd),  .src(id_rs), .en(use_rs), .hit(wb_rs));
  sb_match #(.REG_W(REG_W)) m_wb_rt  (.v(wb.v),  .wd(wb.wd),  .src(id_rt), .en(use_rt), .hit(wb_rt));
  assign unused_wb = mem.ld ^ wb.ld;
`else
  assign wb_rs = 1'b0;
  assign wb_rt = 1'b0;
  assign unused_wb = ^{mem.ld, wb};
`endif
  // only a load still in EX cannot forward in time; everything later is bypassed
  assign stall = ex.ld & (ex_rs | ex_rt);
  assign kill  = stall | flush;
  assign fa_d  = kill ? FWD_RF : ex_rs ? FWD_EXMEM : mem_rs ? FWD_MEMWB : wb_rs ? FWD_WB : FWD_RF;
  assign fb_d  = kill ? FWD_RF : ex_rt ? FWD_EXMEM : mem_rt ? FWD_MEMWB : wb_rt ? FWD_WB : FWD_RF;
  always_ff @(posedge clk) begin
    if (rst) begin
      ex        <= '0;
      mem       <= '0;
      wb        <= '0;
      fwd_a     <= FWD_RF;
      fwd_b     <= FWD_RF;
      stall_cnt <= '0;
    end else begin
      wb    <= mem;
      mem   <= ex;
      ex    <= kill ? '0 : {id_valid & id_wr_en, id_wd, id_is_load};
      fwd_a <= fa_d;
      fwd_b <= fb_d;
      if (stall & ~flush & ~&stall_cnt) stall_cnt <= stall_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_wb_scoreboard.sv
// tb_wb_scoreboard: directed hazard scenarios checked against an age-ordered producer model
module tb_wb_scoreboard;
  logic clk = 0, rst = 1, id_valid = 0, id_wr_en = 0, id_is_load = 0, flush = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_wd = 0;
  logic [1:0] id_ra_sel = 2'b10;
  logic stall;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt;
  int checks = 0, fails = 0;
  bit armed = 0;
  int m_dst[3];
  bit m_ld[3];
  logic [1:0] m_fa = 0, m_fb = 0;
  int m_cnt = 0;
`ifdef WB_SCOREBOARD_WB_BYPASS_EN
  localparam int NA = 3;
`else
  localparam int NA = 2;
`endif
  wb_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_ra_sel(id_ra_sel), .id_wr_en(id_wr_en), .id_wd(id_wd), .id_is_load(id_is_load),
    .flush(flush), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  // m_dst[age]: destination written by the producer that is age+1 stages past ID, 0 = none
  function automatic bit uses(input logic [1:0] sel, input bit rt);
    return id_valid && (sel == 2'b00 || sel == (rt ? 2'b11 : 2'b01));
  endfunction
  function automatic bit m_stall();
    return m_dst[0] != 0 && m_ld[0] &&
      ((uses(id_ra_sel, 0) && m_dst[0] == int'(id_rs)) || (uses(id_ra_sel, 1) && m_dst[0] == int'(id_rt)));
  endfunction
  function automatic logic [1:0] m_fwd(input logic [4:0] src, input bit u);
    for (int a = 0; a < NA; a++)
      if (u && m_dst[a] != 0 && m_dst[a] == int'(src)) return 2'(a + 1);
    return 2'd0;
  endfunction
  always @(posedge clk)
    if (rst) begin
      m_dst <= '{0, 0, 0};
      m_ld  <= '{0, 0, 0};
      m_fa  <= 0;
      m_fb  <= 0;
      m_cnt <= 0;
    end else begin
      m_dst <= '{(m_stall() || flush || !(id_valid && id_wr_en)) ? 0 : int'(id_wd), m_dst[0], m_dst[1]};
      m_ld  <= '{!(m_stall() || flush) && id_is_load, m_ld[0], m_ld[1]};
      m_fa  <= (m_stall() || flush) ? 2'd0 : m_fwd(id_rs, uses(id_ra_sel, 0));
      m_fb  <= (m_stall() || flush) ? 2'd0 : m_fwd(id_rt, uses(id_ra_sel, 1));
      if (m_stall() && !flush && m_cnt < 65535) m_cnt <= m_cnt + 1;
    end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (armed) begin
      check("model_stall", 32'(stall), 32'(m_stall()));
      check("model_fwd_a", 32'(fwd_a), 32'(m_fa));
      check("model_fwd_b", 32'(fwd_b), 32'(m_fb));
      check("model_cnt", 32'(stall_cnt), m_cnt);
    end
  task automatic drive(input bit v, input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] sel,
                       input bit wr, input logic [4:0] wd, input bit ld);
    id_valid = v; id_rs = rs; id_rt = rt; id_ra_sel = sel; id_wr_en = wr; id_wd = wd; id_is_load = ld;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    armed = 1;
    check("rst_stall", 32'(stall), 0);
    check("rst_fwd_a", 32'(fwd_a), 0);
    check("rst_cnt", 32'(stall_cnt), 0);
    // lw $3 ; add $4,$3,$5
    drive(1, 1, 2, 2'b01, 1, 3, 1); tick;
    drive(1, 3, 5, 2'b00, 1, 4, 0); #1 check("lu_stall", 32'(stall), 1);
    tick;
    check("lu_stall_once", 32'(stall), 0);
    check("lu_cnt", 32'(stall_cnt), 1);
    tick;
    check("lu_fwd_a", 32'(fwd_a), 2);
    check("lu_fwd_b", 32'(fwd_b), 0);
    // add $3 ; sub $6,$3,$3
    drive(1, 1, 2, 2'b00, 1, 3, 0); tick;
    drive(1, 3, 3, 2'b00, 1, 6, 0); #1 check("b2b_stall", 32'(stall), 0);
    tick;
    check("b2b_fwd_a", 32'(fwd_a), 1);
    check("b2b_fwd_b", 32'(fwd_b), 1);
    // add $3 ; nop ; or $7,$3,$0
    drive(1, 1, 2, 2'b00, 1, 3, 0); tick;
    drive(0, 0, 0, 2'b10, 0, 0, 0); tick;
    drive(1, 3, 0, 2'b00, 1, 7, 0); tick;
    check("gap_fwd_a", 32'(fwd_a), 2);
    check("gap_fwd_b", 32'(fwd_b), 0);
    // lw $0 ; add $4,$0,$1
    drive(1, 1, 2, 2'b01, 1, 0, 1); tick;
    drive(1, 0, 1, 2'b00, 1, 4, 0); #1 check("r0_stall", 32'(stall), 0);
    tick;
    check("r0_fwd_a", 32'(fwd_a), 0);
    // lw $5 ; shift reading rt only, then no sources
    drive(1, 1, 2, 2'b01, 1, 5, 1); tick;
    drive(1, 5, 5, 2'b11, 1, 8, 0); #1 check("sll_rt_stall", 32'(stall), 1);
    drive(1, 5, 6, 2'b11, 1, 8, 0); #1 check("sll_rs_ignored", 32'(stall), 0);
    drive(1, 5, 5, 2'b10, 1, 8, 0); #1 check("sel_none", 32'(stall), 0);
    tick;
    check("sel_none_cnt", 32'(stall_cnt), 1);
    // load-use coinciding with flush
    drive(1, 1, 2, 2'b01, 1, 3, 1); tick;
    drive(1, 3, 5, 2'b00, 1, 4, 0); flush = 1;
    #1 check("fl_raw_stall", 32'(stall), 1);
    tick;
    flush = 0;
    drive(0, 0, 0, 2'b10, 0, 0, 0);
    #1 check("fl_stall", 32'(stall), 0);
    check("fl_fwd_a", 32'(fwd_a), 0);
    check("fl_fwd_b", 32'(fwd_b), 0);
    check("fl_cnt", 32'(stall_cnt), 1);
    // reset during a stall
    drive(1, 1, 2, 2'b01, 1, 3, 1); tick;
    drive(1, 3, 5, 2'b00, 1, 4, 0); #1 check("rs_pre_stall", 32'(stall), 1);
    rst = 1;
    tick;
    rst = 0;
    check("rs_stall", 32'(stall), 0);
    check("rs_cnt", 32'(stall_cnt), 0);
    check("rs_fwd_a", 32'(fwd_a), 0);
    drive(0, 0, 0, 2'b10, 0, 0, 0);
    repeat (3) tick;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/wb_scoreboard.md
# wb_scoreboard

Writeback-side hazard scoreboard for the 5-stage MIPS pipeline. It consumes the register read-usage decode from ID (rs/rt used, per the 2-bit read-select control) and tracks in-flight destination registers through EX, MEM and WB. It produces the ID stall for load-use hazards and registered forwarding selects for the ALU A/B operand muxes in EX. It sits beside the ID/EX pipeline register and is the consumer of the read-address control.

## Interface
Parameters:
- `REG_W`, 5: register index width.

Ports:
- `clk` input 1: pipeline clock.
- `rst` input 1: synchronous, active-high reset.
- `id_valid` input 1: ID holds a real instruction.
- `id_rs` input REG_W: rs field.
- `id_rt` input REG_W: rt field.
- `id_ra_sel` input 2: read-select code. 00 uses rs+rt; 01 uses rs only; 11 uses rt only (shifts); 10 uses none.
- `id_wr_en` input 1: instruction writes a register.
- `id_wd` input REG_W: destination index.
- `id_is_load` input 1: instruction is a load.
- `flush` input 1: taken branch/jump; kill the instruction entering EX.
- `stall` output 1: hold PC and IF/ID; combinational.
- `fwd_a` output 2: EX operand A source, registered.
- `fwd_b` output 2: EX operand B source, registered.
- `stall_cnt` output 16: saturating count of stall cycles.

## Operation
- Three shadow entries, EX, MEM and WB. Each entry is {v, wd, ld}.
- An entry is live only when v=1 and wd≠0. Register $0 never creates a hazard.
- Source use:
  - use_rs = id_valid & (sel==00 | sel==01).
  - use_rt = id_valid & (sel==00 | sel==11).
- stall = live(EX) & EX.ld & ((use_rs & EX.wd==id_rs) | (use_rt & EX.wd==id_rt)).
- Each clock edge, entries shift WB←MEM and MEM←EX. EX loads as follows:
  - flush=1: EX ← bubble. Flush overrides stall.
  - else stall=1: EX ← bubble.
  - else: EX ← {id_valid&id_wr_en, id_wd, id_is_load}.
- Forward encoding: 00 register file, 01 EX/MEM result, 10 MEM/WB result, 11 WB-bypass (macro only).
- fwd_a is computed in ID and registered in the same edge that loads EX. It uses rs against the pre-edge EX and MEM entries:
  - live EX match → 01.
  - else live MEM match → 10.
  - else → 00.
  - The newest producer has priority.
- fwd_b applies the same rule to rt.
- A source that is not used always gives 00.
- On stall or flush, fwd_a and fwd_b load 00.
- stall_cnt increments on each cycle with stall=1 & !flush. It saturates at 0xFFFF.

## Timing
- Reset: all entries v=0; fwd_a=fwd_b=00; stall_cnt=0. stall=0 the cycle after reset because no entries are live.
- stall has zero latency; it depends only on current state and ID inputs.
- fwd_a/fwd_b are valid in the cycle the consumer occupies EX, which is one edge after ID.
- A load-use hazard gives exactly one stall cycle. On the next cycle the load is in MEM, so the dependent instruction gets 10.
- A WB-stage producer with the consumer in ID reports 00. The register file writes in the first half-cycle and reads in the second, which covers this case.
- rst asserted mid-stream clears everything on the next edge, including a stall in progress.

## Configuration
- Macro `WB_SCOREBOARD_WB_BYPASS_EN`.
- Defined: the WB entry is also compared, at lowest priority after EX and MEM. A match yields code 11, and the EX mux selects the WB write data.
- Undefined: WB is never compared and code 11 is never produced.

## Structure
- Shared package holds:
  - forward codes FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, FWD_WB=2'b11;
  - read-select codes RA_RSRT=2'b00, RA_RS=2'b01, RA_RT=2'b11, RA_NONE=2'b10;
  - REG_W.
- One sub-module, `sb_match`: a combinational comparator taking an entry plus a source index and use flag, and returning a hit. It is instantiated once per (entry, source) pair.

## Test plan
- lw $3 then add $4,$3,$5 (sel 00) → stall=1 for one cycle; then fwd_a=10, fwd_b=00; stall_cnt=1.
- add $3 then sub $6,$3,$3 back-to-back → no stall; fwd_a=fwd_b=01.
- add $3, nop, or $7,$3,$0 → fwd_a=10; rt=$0 → fwd_b=00.
- lw $0 then add $4,$0,$1 → no stall, fwd_a=00 ($0 is never hazardous).
- sll (sel 11) with rt matching a load in EX and rs matching too → stall only on rt. Repeat with sel 10 → no stall.
- lw $3 with a dependent instruction in ID, and flush=1 on the same cycle → EX becomes a bubble, fwd codes 00, stall_cnt unchanged. Assert rst during a stall → stall=0 next cycle, counters 0.
